// File: rtl/conv1_c_accum_rmw.sv
// rtl/conv1_c_accum_rmw.sv - read-modify-write engine feeding the conv1 C accumulator BRAM
//
// Purpose: accepts tagged signed partial sums, reads the current BRAM word,
// adds (or overwrites on the first K tile) with saturation, and writes back.
// A 3-stage pipeline (accept / compute / write) plus an extra write-history
// stage hides the 1-cycle BRAM read latency; forwarding from the two newest
// writes keeps same-address running sums exact at any beat spacing.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   clear_req             one-cycle request to zero the whole BRAM
//   in_valid/in_ready     partial-sum beat handshake
//   in_addr/in_psum       flat C address (m*N_TOTAL+n), signed partial sum
//   in_first/in_last      overwrite (first K tile) / final beat of tile
//   bram_*                BRAM clear, read and write ports
//   tile_done             pulse when the in_last beat's write is issued
//   sat_flag, addr_err    sticky status flags
module conv1_c_accum_rmw #(
  parameter int M_TOTAL = 3136,
  parameter int N_TOTAL = 64,
  parameter int ACC_W_P = 32
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      clear_req,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic signed [31:0]        in_addr,
  input  logic signed [ACC_W_P-1:0] in_psum,
  input  logic                      in_first,
  input  logic                      in_last,
  output logic                      bram_clear_all,
  output logic                      bram_rd_en,
  output logic signed [31:0]        bram_rd_addr,
  input  logic signed [ACC_W_P-1:0] bram_rd_data,
  input  logic                      bram_rd_valid,
  output logic                      bram_wr_en,
  output logic signed [31:0]        bram_wr_addr,
  output logic signed [ACC_W_P-1:0] bram_wr_data,
  output logic                      tile_done,
  output logic                      sat_flag,
  output logic                      addr_err
);

  localparam int DEPTH = M_TOTAL * N_TOTAL;

  localparam logic signed [ACC_W_P-1:0] ACC_MAX = {1'b0, {(ACC_W_P-1){1'b1}}};
  localparam logic signed [ACC_W_P-1:0] ACC_MIN = {1'b1, {(ACC_W_P-1){1'b0}}};

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRAIN = 2'd1,
    ST_CLEAR = 2'd2
  } state_t;

  state_t state_q, state_d;

  // S1: accepted beat waiting for its read data
  logic                      s1_valid_q, s1_valid_d;
  logic signed [31:0]        s1_addr_q,  s1_addr_d;
  logic signed [ACC_W_P-1:0] s1_psum_q,  s1_psum_d;
  logic                      s1_first_q, s1_first_d;
  logic                      s1_last_q,  s1_last_d;
  logic                      s1_rd_q,    s1_rd_d;

  // S2: write stage
  logic                      s2_valid_q, s2_valid_d;
  logic signed [31:0]        s2_addr_q,  s2_addr_d;
  logic signed [ACC_W_P-1:0] s2_sum_q,   s2_sum_d;
  logic                      s2_last_q,  s2_last_d;

  // S3: the write issued last cycle; a read issued in that same cycle
  // returned pre-write data, so S1 must take this value instead
  logic                      s3_valid_q, s3_valid_d;
  logic signed [31:0]        s3_addr_q,  s3_addr_d;
  logic signed [ACC_W_P-1:0] s3_data_q,  s3_data_d;

  logic sat_flag_q, sat_flag_d;
  logic addr_err_q, addr_err_d;

  logic                      accept;
  logic                      addr_ok;
  logic                      beat_ok;
  logic signed [ACC_W_P-1:0] base;
  logic        [ACC_W_P:0]   sum_wide;
  logic                      ovf;
  logic signed [ACC_W_P-1:0] sum_sat;

  always_comb begin
    in_ready = (state_q == ST_IDLE);
    accept   = in_valid && in_ready;
    addr_ok  = (in_addr >= 0) && (in_addr < DEPTH);
    beat_ok  = accept && addr_ok;

    bram_rd_en     = beat_ok && !in_first;
    bram_rd_addr   = in_addr;
    bram_clear_all = (state_q == ST_CLEAR);
    bram_wr_en     = s2_valid_q;
    bram_wr_addr   = s2_addr_q;
    bram_wr_data   = s2_sum_q;
    tile_done      = s2_valid_q && s2_last_q;
    sat_flag       = sat_flag_q;
    addr_err       = addr_err_q;
  end

  // Base selection: S2 is newer than S3, so it wins when both match.
  always_comb begin
    base = bram_rd_data;
    if (s1_first_q) begin
      base = '0;
    end else if (s2_valid_q && (s2_addr_q == s1_addr_q)) begin
      base = s2_sum_q;
    end else if (s3_valid_q && (s3_addr_q == s1_addr_q)) begin
      base = s3_data_q;
    end

    // One guard bit: overflow shows as the top two bits disagreeing.
    sum_wide = {base[ACC_W_P-1], base} + {s1_psum_q[ACC_W_P-1], s1_psum_q};
    ovf      = sum_wide[ACC_W_P] != sum_wide[ACC_W_P-1];
    if (!ovf) begin
      sum_sat = sum_wide[ACC_W_P-1:0];
    end else if (sum_wide[ACC_W_P]) begin
      sum_sat = ACC_MIN;
    end else begin
      sum_sat = ACC_MAX;
    end
  end

  always_comb begin
    s1_valid_d = beat_ok;
    s1_addr_d  = in_addr;
    s1_psum_d  = in_psum;
    s1_first_d = in_first;
    s1_last_d  = in_last;
    s1_rd_d    = bram_rd_en;

    s2_valid_d = s1_valid_q;
    s2_addr_d  = s1_addr_q;
    s2_sum_d   = sum_sat;
    s2_last_d  = s1_last_q;

    s3_valid_d = s2_valid_q && (state_q != ST_CLEAR);
    s3_addr_d  = s2_addr_q;
    s3_data_d  = s2_sum_q;

    sat_flag_d = sat_flag_q || (s1_valid_q && ovf);
    // A read whose data is not flagged valid means the BRAM latency is not 1.
    addr_err_d = addr_err_q || (accept && !addr_ok)
                 || (s1_valid_q && s1_rd_q && !bram_rd_valid);
    if (state_q == ST_CLEAR) begin
      sat_flag_d = 1'b0;
      addr_err_d = 1'b0;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (clear_req) state_d = ST_DRAIN;
      ST_DRAIN: if (!s1_valid_q && !s2_valid_q) state_d = ST_CLEAR;
      ST_CLEAR: state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      s1_valid_q <= 1'b0;
      s1_addr_q  <= '0;
      s1_psum_q  <= '0;
      s1_first_q <= 1'b0;
      s1_last_q  <= 1'b0;
      s1_rd_q    <= 1'b0;
      s2_valid_q <= 1'b0;
      s2_addr_q  <= '0;
      s2_sum_q   <= '0;
      s2_last_q  <= 1'b0;
      s3_valid_q <= 1'b0;
      s3_addr_q  <= '0;
      s3_data_q  <= '0;
      sat_flag_q <= 1'b0;
      addr_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      s1_valid_q <= s1_valid_d;
      s1_addr_q  <= s1_addr_d;
      s1_psum_q  <= s1_psum_d;
      s1_first_q <= s1_first_d;
      s1_last_q  <= s1_last_d;
      s1_rd_q    <= s1_rd_d;
      s2_valid_q <= s2_valid_d;
      s2_addr_q  <= s2_addr_d;
      s2_sum_q   <= s2_sum_d;
      s2_last_q  <= s2_last_d;
      s3_valid_q <= s3_valid_d;
      s3_addr_q  <= s3_addr_d;
      s3_data_q  <= s3_data_d;
      sat_flag_q <= sat_flag_d;
      addr_err_q <= addr_err_d;
    end
  end

endmodule

// File: tb/tb_conv1_c_accum_rmw.sv
// tb/tb_conv1_c_accum_rmw.sv - directed self-checking bench for conv1_c_accum_rmw
module tb_conv1_c_accum_rmw;

  localparam int DEPTH = 3136 * 64;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               clear_req;
  logic               in_valid;
  logic               in_ready;
  logic signed [31:0] in_addr;
  logic signed [31:0] in_psum;
  logic               in_first;
  logic               in_last;
  logic               bram_clear_all;
  logic               bram_rd_en;
  logic signed [31:0] bram_rd_addr;
  logic signed [31:0] bram_rd_data = '0;
  logic               bram_rd_valid = 1'b0;
  logic               bram_wr_en;
  logic signed [31:0] bram_wr_addr;
  logic signed [31:0] bram_wr_data;
  logic               tile_done;
  logic               sat_flag;
  logic               addr_err;

  conv1_c_accum_rmw #(.M_TOTAL(3136), .N_TOTAL(64), .ACC_W_P(32)) dut (
    .clk(clk), .rst_n(rst_n), .clear_req(clear_req),
    .in_valid(in_valid), .in_ready(in_ready), .in_addr(in_addr),
    .in_psum(in_psum), .in_first(in_first), .in_last(in_last),
    .bram_clear_all(bram_clear_all), .bram_rd_en(bram_rd_en),
    .bram_rd_addr(bram_rd_addr), .bram_rd_data(bram_rd_data),
    .bram_rd_valid(bram_rd_valid), .bram_wr_en(bram_wr_en),
    .bram_wr_addr(bram_wr_addr), .bram_wr_data(bram_wr_data),
    .tile_done(tile_done), .sat_flag(sat_flag), .addr_err(addr_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // BRAM model: read-first on a same-cycle read/write, 1-cycle read latency
  logic signed [31:0] mem [int];
  logic               poke_en = 1'b0;
  int                 poke_addr = 0;
  logic signed [31:0] poke_data = '0;

  always @(posedge clk) begin
    if (bram_rd_en) bram_rd_data <= mem.exists(bram_rd_addr) ? mem[bram_rd_addr] : 32'sd0;
    bram_rd_valid <= bram_rd_en;
    if (bram_clear_all) mem.delete();
    if (bram_wr_en) mem[bram_wr_addr] = bram_wr_data;
    if (poke_en) mem[poke_addr] = poke_data;
  end

  typedef struct {
    int addr;
    int data;
    int cyc;
  } wr_t;

  wr_t wr_log[$];
  int  td_log[$];
  int  clr_log[$];

  always @(negedge clk) begin
    if (rst_n) begin
      if (bram_wr_en) begin
        wr_t e;
        e.addr = bram_wr_addr;
        e.data = bram_wr_data;
        e.cyc  = cyc;
        wr_log.push_back(e);
      end
      if (tile_done) td_log.push_back(cyc);
      if (bram_clear_all) clr_log.push_back(cyc);
    end
  end

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic signed [63:0] got, input logic signed [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic wr_t get_wr(input int i);
    wr_t e;
    e.addr = -999; e.data = -999; e.cyc = -999;
    if (i < wr_log.size()) e = wr_log[i];
    return e;
  endfunction

  int   drv_cyc;
  logic rd_seen;
  logic signed [31:0] rd_addr_seen;

  task automatic beat(input int a, input int p, input logic f, input logic l);
    in_valid = 1'b1; in_addr = a; in_psum = p; in_first = f; in_last = l;
    drv_cyc = cyc;
    @(negedge clk);
    rd_seen = bram_rd_en;
    rd_addr_seen = bram_rd_addr;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic clear_logs();
    wr_log.delete(); td_log.delete(); clr_log.delete();
  endtask

  int k1, k2, h, acc_cyc, clr_cyc, ca;
  logic first_rdy;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; clear_req = 1'b0; in_valid = 1'b0;
    in_addr = 0; in_psum = 0; in_first = 1'b0; in_last = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_wr_en", bram_wr_en, 0);
    chk("rst_clear_all", bram_clear_all, 0);
    chk("rst_tile_done", tile_done, 0);
    chk("rst_sat", sat_flag, 0);
    chk("rst_addr_err", addr_err, 0);
    chk("rst_rd_en", bram_rd_en, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    idle(2);

    // single beats to addr 5: overwrite 10, then accumulate -3
    clear_logs();
    beat(5, 10, 1'b1, 1'b0); k1 = drv_cyc;
    chk("s_first_no_rd", rd_seen, 0);
    idle(3);
    beat(5, -3, 1'b0, 1'b0); k2 = drv_cyc;
    chk("s_rd_en", rd_seen, 1);
    chk("s_rd_addr", rd_addr_seen, 5);
    idle(4);
    chk("s_nwr", wr_log.size(), 2);
    chk("s_wr0_data", get_wr(0).data, 10);
    chk("s_wr0_lat", get_wr(0).cyc - k1, 2);
    chk("s_wr1_addr", get_wr(1).addr, 5);
    chk("s_wr1_data", get_wr(1).data, 7);
    chk("s_wr1_lat", get_wr(1).cyc - k2, 2);

    // back-to-back same address: S2 forwarding
    clear_logs();
    beat(7, 1, 1'b1, 1'b0); h = drv_cyc;
    beat(7, 2, 1'b0, 1'b0);
    beat(7, 3, 1'b0, 1'b0);
    beat(7, 4, 1'b0, 1'b1);
    idle(4);
    chk("h_nwr", wr_log.size(), 4);
    chk("h_wr0", get_wr(0).data, 1);
    chk("h_wr1", get_wr(1).data, 3);
    chk("h_wr2", get_wr(2).data, 6);
    chk("h_wr3", get_wr(3).data, 10);
    chk("h_wr3_cyc", get_wr(3).cyc, h + 5);
    chk("h_ntd", td_log.size(), 1);
    chk("h_td_cyc", (td_log.size() > 0) ? td_log[0] : -1, h + 5);

    // spacing 2: S3 forwarding
    clear_logs();
    beat(7, 1, 1'b1, 1'b0);
    beat(8, 1, 1'b1, 1'b0);
    beat(7, 2, 1'b0, 1'b0);
    beat(8, 2, 1'b0, 1'b0);
    idle(4);
    chk("h2_nwr", wr_log.size(), 4);
    chk("h2_wr2_addr", get_wr(2).addr, 7);
    chk("h2_wr2", get_wr(2).data, 3);
    chk("h2_wr3_addr", get_wr(3).addr, 8);
    chk("h2_wr3", get_wr(3).data, 3);

    // saturation, both directions
    poke_en = 1'b1; poke_addr = 0; poke_data = 32'sh7FFFFFF0;
    idle(1);
    poke_addr = 1; poke_data = 32'sh80000000;
    idle(1);
    poke_en = 1'b0;
    clear_logs();
    chk("sat_pre", sat_flag, 0);
    beat(0, 32'sh20, 1'b0, 1'b0);
    idle(3);
    chk("sat_pos", get_wr(0).data, 32'sh7FFFFFFF);
    chk("sat_flag", sat_flag, 1);
    beat(1, -1, 1'b0, 1'b0);
    idle(3);
    chk("sat_neg", get_wr(1).data, -64'sd2147483648);

    // out-of-range addresses are consumed bubbles
    clear_logs();
    chk("oor_pre", addr_err, 0);
    beat(DEPTH, 3, 1'b0, 1'b1);
    chk("oor_hi_rd", rd_seen, 0);
    beat(-1, 3, 1'b0, 1'b1);
    chk("oor_neg_rd", rd_seen, 0);
    beat(9, 5, 1'b1, 1'b0);
    idle(4);
    chk("oor_err", addr_err, 1);
    chk("oor_nwr", wr_log.size(), 1);
    chk("oor_next_addr", get_wr(0).addr, 9);
    chk("oor_next_data", get_wr(0).data, 5);
    chk("oor_ntd", td_log.size(), 0);

    // clear with two beats in flight; beat C waits at the input
    clear_logs();
    beat(20, 4, 1'b1, 1'b0); ca = drv_cyc;
    clear_req = 1'b1;
    beat(21, 6, 1'b1, 1'b1);
    clear_req = 1'b0;
    in_valid = 1'b1; in_addr = 30; in_psum = 9; in_first = 1'b1; in_last = 1'b0;
    acc_cyc = -1; first_rdy = 1'b1;
    for (int n = 0; n < 30 && acc_cyc < 0; n++) begin
      @(negedge clk);
      if (n == 0) first_rdy = in_ready;
      if (in_ready) acc_cyc = cyc;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    idle(4);
    clr_cyc = (clr_log.size() > 0) ? clr_log[0] : -100;
    chk("c_timeout", acc_cyc >= 0, 1);
    chk("c_busy_next", first_rdy, 0);
    chk("c_nclr", clr_log.size(), 1);
    chk("c_ready_after", acc_cyc, clr_cyc + 1);
    chk("c_nwr", wr_log.size(), 3);
    chk("c_wrA", get_wr(0).data, 4);
    chk("c_wrB_addr", get_wr(1).addr, 21);
    chk("c_wrB_before", get_wr(1).cyc < clr_cyc, 1);
    chk("c_td", (td_log.size() > 0) ? td_log[0] : -1, ca + 3);
    chk("c_wrC_addr", get_wr(2).addr, 30);
    chk("c_wrC_cyc", get_wr(2).cyc, acc_cyc + 2);
    chk("c_sat_clr", sat_flag, 0);
    chk("c_err_clr", addr_err, 0);

    // reset with S1 and S2 occupied drops both beats
    clear_logs();
    beat(40, 1, 1'b1, 1'b0);
    beat(41, 2, 1'b1, 1'b1);
    rst_n = 1'b0;
    @(negedge clk);
    chk("r_wr_en", bram_wr_en, 0);
    chk("r_tile_done", tile_done, 0);
    idle(2);
    rst_n = 1'b1;
    idle(6);
    chk("r_nwr", wr_log.size(), 0);
    chk("r_ntd", td_log.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
